addsub_accumulator: RTL

- Sequential accumulator stage wrapped around the nBitAddSub ripple adder/subtractor.
- Drives the adder's a, b and m inputs from registered state, then captures sum/cout into an accumulator register with status flags.
- Accepts one operation per valid/ready handshake, reports completion with a one-cycle out_valid pulse, and counts completed operations.

---
 rtl/addsub_accumulator.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/addsub_accumulator.sv
// Accumulator stage around an external nBitAddSub ripple adder/subtractor.
// It registers the adder operands, commits sum/carry with status flags, and
// counts operations using a valid/ready handshake.
// Build option: define ADDSUB_STICKY_OVF_EN to make ovf_flag sticky until CLEAR/reset.
module addsub_accumulator #(
   parameter int N = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [1:0]   op,
   input  logic [N-1:0] operand,
   output logic [N-1:0] a_o,
   output logic [N-1:0] b_o,
   output logic         m_o,
   input  logic [N-1:0] sum_i,
   input  logic         cout_i,
   output logic [N-1:0] acc,
   output logic         carry_flag,
   output logic         ovf_flag,
   output logic         zero_flag,
   output logic         out_valid,
   output logic [7:0]   op_count
);

   typedef enum logic {
      S_IDLE,
      S_EXEC
   } state_e;

   typedef enum logic [1:0] {
      OP_LOAD  = 2'b00,
      OP_ADD   = 2'b01,
      OP_SUB   = 2'b10,
      OP_CLEAR = 2'b11
   } op_e;

   state_e       r_state;
   op_e          r_op;
   logic [N-1:0] r_b;
   logic         r_m;
   logic [N-1:0] r_acc;
   logic         r_carry;
   logic         r_ovf;
   logic         r_zero;
   logic         r_out_valid;
   logic [7:0]   r_op_count;

   state_e       w_state_next;
   logic         w_accept;
   logic         w_commit;
   logic         w_in_ready;
   logic [N-1:0] w_acc_next;
   logic         w_carry_next;
   logic         w_ovf_next;
   logic         w_add_ovf;
   logic         w_sub_ovf;

   // Signed overflow: the result sign disagrees with the accumulator sign
   // even though the effective operand signs allow no such change.
   assign w_add_ovf = (r_acc[N-1] == r_b[N-1]) && (sum_i[N-1] != r_acc[N-1]);
   assign w_sub_ovf = (r_acc[N-1] != r_b[N-1]) && (sum_i[N-1] != r_acc[N-1]);

   // NOTE: every signal written here gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_commit     = 1'b0;
      w_in_ready   = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_in_ready = 1'b1;
            if (in_valid) begin
               w_accept     = 1'b1;
               w_state_next = S_EXEC;
            end
         end
         S_EXEC: begin
            w_commit     = 1'b1;
            w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_acc_next   = r_acc;
      w_carry_next = r_carry;
      w_ovf_next   = r_ovf;
      case (r_op)
         OP_LOAD: begin
            w_acc_next   = r_b;
            w_carry_next = 1'b0;
`ifdef ADDSUB_STICKY_OVF_EN
            w_ovf_next   = r_ovf;
`else
            w_ovf_next   = 1'b0;
`endif
         end
         OP_ADD: begin
            w_acc_next   = sum_i;
            w_carry_next = cout_i;
`ifdef ADDSUB_STICKY_OVF_EN
            w_ovf_next   = r_ovf | w_add_ovf;
`else
            w_ovf_next   = w_add_ovf;
`endif
         end
         OP_SUB: begin
            // Carry out of a + ~b + 1 is high exactly when no borrow occurred.
            w_acc_next   = sum_i;
            w_carry_next = cout_i;
`ifdef ADDSUB_STICKY_OVF_EN
            w_ovf_next   = r_ovf | w_sub_ovf;
`else
            w_ovf_next   = w_sub_ovf;
`endif
         end
         OP_CLEAR: begin
            w_acc_next   = '0;
            w_carry_next = 1'b0;
            w_ovf_next   = 1'b0;
         end
         default: begin
            w_acc_next   = r_acc;
            w_carry_next = r_carry;
            w_ovf_next   = r_ovf;
         end
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so that every
   // register samples the values from before the edge, whatever the order.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_op        <= OP_LOAD;
         r_b         <= '0;
         r_m         <= 1'b0;
         r_acc       <= '0;
         r_carry     <= 1'b0;
         r_ovf       <= 1'b0;
         r_zero      <= 1'b1;
         r_out_valid <= 1'b0;
         r_op_count  <= 8'd0;
      end else begin
         r_state     <= w_state_next;
         r_out_valid <= w_commit;
         if (w_accept) begin
            r_op <= op_e'(op);
            r_b  <= operand;
            r_m  <= (op_e'(op) == OP_SUB);
         end
         if (w_commit) begin
            r_acc      <= w_acc_next;
            r_carry    <= w_carry_next;
            r_ovf      <= w_ovf_next;
            r_zero     <= (w_acc_next == '0);
            r_op_count <= r_op_count + 8'd1;
         end
      end
   end

   assign in_ready   = w_in_ready;
   assign a_o        = r_acc;
   assign b_o        = r_b;
   assign m_o        = r_m;
   assign acc        = r_acc;
   assign carry_flag = r_carry;
   assign ovf_flag   = r_ovf;
   assign zero_flag  = r_zero;
   assign out_valid  = r_out_valid;
   assign op_count   = r_op_count;

endmodule
